niosqsys_pio_in_edge: RTL and testbench

Parametrised Avalon-MM slave input port. It is the successor to the 4-bit read-only switch PIO, for switches, keys and other asynchronous inputs on the Nios system bus. It adds the following to the plain data read:
- Input synchronisation.
- Per-bit edge capture with write-1-to-clear.
- An interrupt mask register driving a level IRQ to the CPU.

---
 rtl/niosqsys_pio_in_edge.sv | 161 ++++++++++++++++
 tb/tb_niosqsys_pio_in_edge.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/niosqsys_pio_in_edge.sv
// niosqsys_pio_in_edge -- Avalon-MM input PIO with synchroniser, per-bit edge
// capture (write-1-to-clear) and a masked level interrupt.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   address[1:0]        word address: 0 data(RO) 1 reserved 2 irqmask 3 edgecapture(W1C)
//   chipselect, write_n write when chipselect=1 and write_n=0
//   writedata[31:0]     write data (bits above WIDTH ignored)
//   readdata[31:0]      registered read data, 1-cycle latency, zero-extended
//   in_port[WIDTH-1:0]  asynchronous external inputs
//   irq                 |(edgecapture & irqmask), active high
//
// Build option: define DEBOUNCE_EN to insert a per-bit stability filter of
// DEBOUNCE_CYCLES cycles between the synchroniser and the edge detector.

`ifdef DEBOUNCE_EN
// Per-bit debounce lane: filt follows sync only after it has disagreed for
// CYCLES consecutive cycles.
module niosqsys_pio_in_edge_db #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_i,
  output logic filt_o
);
  logic [15:0] cnt_q, cnt_d;
  logic        filt_q, filt_d;

  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_i != filt_q) begin
      if (cnt_q == 16'(CYCLES - 1)) filt_d = sync_i;
      else                          cnt_d  = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;
endmodule
`endif

module niosqsys_pio_in_edge #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  localparam int STARTUP = SYNC_STAGES + 1;
  localparam int CW      = $clog2(STARTUP + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_out, filt;
  logic [WIDTH-1:0] prev_q, irqmask_q, irqmask_d, edgecap_q, edgecap_d;
  logic [WIDTH-1:0] edge_vec, w1c;
  logic [31:0]      readdata_q, readdata_d;
  logic [CW-1:0]    start_q, start_d;
  logic             armed, wr_en;
  logic             unused_wd;

  // Synchroniser chain: stage 0 samples the pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    niosqsys_pio_in_edge_db #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .sync_i (sync_out[i]),
      .filt_o (filt[i])
    );
  end
`else
  logic [15:0] unused_db;
  assign unused_db = 16'(DEBOUNCE_CYCLES);
  assign filt      = sync_out;
`endif

  // Startup guard: edges are suppressed until the sync chain and prev have
  // been loaded with real pin values, so inputs held high through reset do
  // not look like rising edges.
  assign armed   = (start_q == CW'(STARTUP));
  assign start_d = armed ? start_q : start_q + CW'(1);

  always_comb begin
    edge_vec = '0;
    if (armed) begin
      case (EDGE_TYPE)
        0:       edge_vec = filt & ~prev_q;
        1:       edge_vec = ~filt & prev_q;
        default: edge_vec = filt ^ prev_q;
      endcase
    end
  end

  assign wr_en     = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  // Clear is applied first and the new edge OR-ed in, so a coincident edge wins.
  always_comb begin
    w1c       = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    edgecap_d = (edgecap_q & ~w1c) | edge_vec;
    irqmask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = filt;
      2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      start_q    <= '0;
    end else begin
      prev_q     <= filt;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      start_q    <= start_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);
endmodule

// File: tb/tb_niosqsys_pio_in_edge.sv
// Directed bench for niosqsys_pio_in_edge. Two instances share the bus and
// pins: u_dut captures rising edges, u_any captures both edges.
module tb_niosqsys_pio_in_edge;
`ifdef DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif
  localparam int SS  = 2;
  localparam int LAT = SS + DB;   // in_port -> filt
  localparam logic [31:0] ST_EC = (DB != 0) ? 32'hF : 32'h0;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0, write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = 4'hF;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    bit          dut;
  } exp_t;
  exp_t sb[$];
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  niosqsys_pio_in_edge #(.WIDTH(4), .SYNC_STAGES(SS), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0)
  );
  niosqsys_pio_in_edge #(.WIDTH(4), .SYNC_STAGES(SS), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in_port), .irq(irq1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e0, input logic [31:0] e1, input string tag);
    exp_t x;
    address = a; chipselect = 1'b1; write_n = 1'b1;
    sb.push_back('{tag: tag, exp: e0, dut: 1'b0});
    sb.push_back('{tag: {tag, "/any"}, exp: e1, dut: 1'b1});
    tick();
    chipselect = 1'b0;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      chk(x.tag, x.dut ? rd1 : rd0, x.exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with inputs held high, startup guard
    repeat (3) tick();
    chk("rst_rdata", rd0, 32'h0);
    chk("rst_irq", {31'b0, irq0}, 32'h0);
    reset_n = 1'b1;
    repeat (LAT - 1) tick();
    rd(2'd0, 32'h0, 32'h0, "data_pre_sync");
    rd(2'd0, 32'hF, 32'hF, "data_sync");
    rd(2'd3, ST_EC, ST_EC, "ec_startup");
    chk("irq_startup", {31'b0, irq0}, 32'h0);
    wr(2'd3, 32'hF);

    // 2: rising edge latency, irq, W1C
    wr(2'd2, 32'h5);
    in_port = 4'h0;
    repeat (LAT + 2) tick();
    in_port = 4'h1;
    repeat (LAT) tick();
    chk("irq_before_edge", {31'b0, irq0}, 32'h0);
    tick();
    chk("irq_rise", {31'b0, irq0}, 32'h1);
    rd(2'd3, 32'h1, 32'hF, "ec_rise0");
    wr(2'd3, 32'h1);
    chk("irq_w1c", {31'b0, irq0}, 32'h0);

    // 3: masked edge, then unmask
    in_port = 4'h3;
    repeat (LAT + 1) tick();
    chk("irq_masked", {31'b0, irq0}, 32'h0);
    rd(2'd3, 32'h2, 32'hE, "ec_bit1");
    wr(2'd2, 32'h2);
    chk("irq_unmask", {31'b0, irq0}, 32'h1);
    rd(2'd2, 32'h2, 32'h2, "mask_rb");

    // 4: W1C coincident with a new edge on bit 2
    in_port = 4'h7;
    repeat (LAT) tick();
    wr(2'd3, 32'hF);
    rd(2'd3, 32'h4, 32'h4, "ec_set_wins");
    chk("irq_bit2_masked", {31'b0, irq0}, 32'h0);

    // 5: falling edge (any-edge instance), reserved/RO registers, upper bits
    wr(2'd3, 32'hF);
    in_port = 4'h6;
    repeat (LAT + 1) tick();
    rd(2'd3, 32'h0, 32'h1, "ec_fall");
    wr(2'd3, 32'hF);
    in_port = 4'h7;
    repeat (LAT + 1) tick();
    rd(2'd3, 32'h1, 32'h1, "ec_rise_any");
    rd(2'd1, 32'h0, 32'h0, "rsvd");
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'h0, 32'h0, "rsvd_wr");
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, 32'h7, 32'h7, "data_ro");
    wr(2'd2, 32'hFFFF_FFF0);
    rd(2'd2, 32'h0, 32'h0, "mask_hi_bits");

    // reset mid-operation
    wr(2'd2, 32'h1);
    chk("irq_pre_rst", {31'b0, irq0}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("irq_async_rst", {31'b0, irq0}, 32'h0);
    chk("rd_async_rst", rd0, 32'h0);
    chk("rd_async_rst/any", rd1, 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    repeat (SS + 2) tick();
    rd(2'd3, 32'h0, 32'h0, "ec_guard_rearm");
    chk("irq_after_rst", {31'b0, irq0}, 32'h0);

`ifdef DEBOUNCE_EN
    // 6: glitch rejection and debounced level
    repeat (LAT + 2) tick();
    wr(2'd3, 32'hF);
    in_port = 4'hF;
    repeat (10) tick();
    in_port = 4'h7;
    repeat (LAT + 2) tick();
    rd(2'd0, 32'h7, 32'h7, "db_glitch_data");
    rd(2'd3, 32'h0, 32'h0, "db_glitch_ec");
    in_port = 4'hF;
    repeat (LAT - 1) tick();
    rd(2'd0, 32'h7, 32'h7, "db_pre");
    rd(2'd0, 32'hF, 32'hF, "db_data");
    rd(2'd3, 32'h8, 32'h8, "db_ec");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
